handshake_monitor: RTL and testbench
====================================

HANDSHAKE_MONITOR -- requirements
Module: handshake_monitor

Interface
REQ-001 The block SHALL have parameter N_CH, default 3: number of monitored ready/valid channels (>=1).
REQ-002 The block SHALL have parameter DATA_W, default 4: payload width per channel (>=1).
REQ-003 The block SHALL have parameter CNT_W, default 8: transfer counter width per channel (>=2).
REQ-004 The block SHALL have parameter TIMEOUT, default 16: consecutive stalled cycles that raise a timeout (2..2^CNT_W-1).
REQ-005 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port ASYNCRESET, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port valid, input, N_CH bits: bit i is producer valid of channel i.
REQ-008 The block SHALL have port ready, input, N_CH bits: bit i is consumer ready of channel i.
REQ-009 The block SHALL have port data, input, N_CH*DATA_W bits: channel i payload in bits [i*DATA_W +: DATA_W].
REQ-010 The block SHALL have port clear, input, 1 bit: synchronous clear of counters and sticky flags.
REQ-011 The block SHALL have port xfer_count, output, N_CH*CNT_W bits: channel i completed-transfer count in [i*CNT_W +: CNT_W].
REQ-012 The block SHALL have port err_drop, output, N_CH bits: sticky, valid withdrawn before transfer.
REQ-013 The block SHALL have port err_data, output, N_CH bits: sticky, payload changed while stalled.
REQ-014 The block SHALL have port err_timeout, output, N_CH bits: sticky, stall reached TIMEOUT cycles.
REQ-015 The block SHALL have port any_error, output, 1 bit: OR of all err_* bits, registered.

Function
REQ-016 Each channel SHALL be monitored independently; channels SHALL have no effect on one another.
REQ-017 Transfer on channel i SHALL be a sampled edge with valid[i]=1 and ready[i]=1.
REQ-018 Each channel SHALL run a two-state FSM: IDLE and PENDING.
REQ-019 IDLE->PENDING SHALL occur on an edge sampling valid=1, ready=0; the FSM SHALL capture data and set stall_cnt=1.
REQ-020 In PENDING, valid=1, ready=0 SHALL stay in PENDING, incrementing stall_cnt (saturating at TIMEOUT).
REQ-021 In PENDING, valid=1, ready=1 SHALL return to IDLE with stall_cnt=0.
REQ-022 In PENDING, valid=0 SHALL set err_drop[i] and return to IDLE with stall_cnt=0.
REQ-023 In PENDING, valid=1 with data different from the captured payload SHALL set err_data[i]; capture SHALL NOT update.
REQ-024 err_timeout[i] SHALL set on the edge where stall_cnt would reach TIMEOUT; it SHALL set once per stall, and further stalled cycles SHALL NOT re-trigger it.
REQ-025 All err_* flags and xfer_count SHALL be registered; a violation sampled at edge k SHALL be visible after edge k; any_error SHALL follow one edge later.
REQ-026 xfer_count[i] SHALL increment by 1 per transfer and saturate at 2^CNT_W-1 (no wrap).
REQ-027 A transfer in IDLE (valid and ready both 1 on the first cycle) SHALL count and stay in IDLE, with no stall.
REQ-028 clear=1 SHALL zero all xfer_count and err_* bits at that edge; FSM state, capture and stall_cnt SHALL be unaffected.
REQ-029 Simultaneous clear and event SHALL apply the event after the clear: a transfer gives count=1, and a violation leaves its flag set.
REQ-030 Err_* flags SHALL be sticky until clear or reset.
REQ-031 ready=1 with valid=0 SHALL be legal and SHALL have no effect.

Reset
REQ-032 On ASYNCRESET=1, all FSMs SHALL go to IDLE immediately, regardless of CLK.
REQ-033 On ASYNCRESET=1, stall_cnt, capture registers, xfer_count, err_drop, err_data, err_timeout and any_error SHALL go to 0 immediately, regardless of CLK.
REQ-034 Reset asserted mid-stall SHALL discard the pending transaction with no error reported; monitoring SHALL resume on the first edge after deassertion.

Verification (N_CH=3, DATA_W=4, CNT_W=8, TIMEOUT=4)
REQ-035 Scenario 1: ch0 valid=ready=1 for 5 edges, data 0..4 -> xfer_count[0]=5; ch1 and ch2 counts are 0; all err_* are 0.
REQ-036 Scenario 2: ch1 valid=1, ready=0, data=0xA for 2 edges, then valid=0 -> err_drop=3'b010 after that edge; any_error=1 one edge later; xfer_count[1]=0.
REQ-037 Scenario 3: ch2 stalls with data=0x5, then data=0x6 while still stalled -> err_data=3'b100; a later transfer gives xfer_count[2]=1.
REQ-038 Scenario 4: ch0 valid=1, ready=0 for 4 edges -> err_timeout[0]=1 after the 4th edge; 6 more stalled edges leave it 1; a transfer gives count +1.
REQ-039 Scenario 5: ch0 count=255 plus 1 transfer -> stays 255; clear with a same-cycle ch0 transfer -> count=1 and all flags 0.
REQ-040 Scenario 6: ASYNCRESET pulsed between edges mid-stall with err bits set -> all outputs 0 before the next edge; valid=0 after deassertion -> no err_drop.

Source files
------------

// File: rtl/handshake_monitor_if.sv
// Bundle of per-channel ready/valid observation signals and monitor results.
// The master side drives the observed traffic; the monitor is the slave.
interface handshake_monitor_if #(
    parameter int N_CH   = 3,
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) ();
    logic [N_CH-1:0]        valid;
    logic [N_CH-1:0]        ready;
    logic [N_CH*DATA_W-1:0] data;
    logic                   clear;
    logic [N_CH*CNT_W-1:0]  xfer_count;
    logic [N_CH-1:0]        err_drop;
    logic [N_CH-1:0]        err_data;
    logic [N_CH-1:0]        err_timeout;
    logic                   any_error;

    modport master (
        output valid, ready, data, clear,
        input  xfer_count, err_drop, err_data, err_timeout, any_error
    );

    modport slave (
        input  valid, ready, data, clear,
        output xfer_count, err_drop, err_data, err_timeout, any_error
    );
endinterface

// File: rtl/handshake_monitor.sv
// Passive protocol checker for N_CH independent ready/valid channels: counts
// transfers and raises sticky drop / data-change / stall-timeout flags.
module handshake_monitor #(
    parameter int N_CH    = 3,
    parameter int DATA_W  = 4,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                 CLK,
    input  logic                 ASYNCRESET,
    handshake_monitor_if.slave   mon
);
    typedef enum logic {ST_IDLE = 1'b0, ST_PENDING = 1'b1} state_t;

    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [N_CH-1:0]       w_err_drop;
    logic [N_CH-1:0]       w_err_data;
    logic [N_CH-1:0]       w_err_timeout;
    logic [N_CH*CNT_W-1:0] w_xfer_count;
    logic                  r_any_error;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            state_t            r_state, w_state_next;
            logic [CNT_W-1:0]  r_stall, w_stall_next;
            logic [CNT_W-1:0]  r_count;
            logic [DATA_W-1:0] r_capture, w_capture_next;
            logic [DATA_W-1:0] w_data;
            logic              w_valid, w_ready, w_xfer;
            logic              w_drop, w_mismatch, w_timeout;
            logic              r_drop, r_mismatch, r_timeout;

            assign w_valid = mon.valid[gi];
            assign w_ready = mon.ready[gi];
            assign w_data  = mon.data[gi*DATA_W +: DATA_W];
            assign w_xfer  = w_valid & w_ready;

            always_comb begin
                w_state_next   = r_state;
                w_stall_next   = r_stall;
                w_capture_next = r_capture;
                w_drop         = 1'b0;
                w_mismatch     = 1'b0;
                w_timeout      = 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        if (w_valid && !w_ready) begin
                            w_state_next   = ST_PENDING;
                            w_capture_next = w_data;
                            w_stall_next   = CNT_W'(1);
                        end
                    end
                    ST_PENDING: begin
                        if (!w_valid) begin
                            w_drop       = 1'b1;
                            w_state_next = ST_IDLE;
                            w_stall_next = '0;
                        end else begin
                            w_mismatch = (w_data != r_capture);
                            if (w_ready) begin
                                w_state_next = ST_IDLE;
                                w_stall_next = '0;
                            end else begin
                                // Saturating at TIMEOUT keeps the flag to one pulse per stall.
                                if (r_stall < TO_VAL) begin
                                    w_stall_next = r_stall + CNT_W'(1);
                                end
                                w_timeout = (r_stall == TO_LAST);
                            end
                        end
                    end
                    default: begin
                        w_state_next = ST_IDLE;
                        w_stall_next = '0;
                    end
                endcase
            end

            always_ff @(posedge CLK or posedge ASYNCRESET) begin
                if (ASYNCRESET) begin
                    r_state   <= ST_IDLE;
                    r_stall   <= '0;
                    r_capture <= '0;
                end else begin
                    r_state   <= w_state_next;
                    r_stall   <= w_stall_next;
                    r_capture <= w_capture_next;
                end
            end

            // Clear wipes history first, then this edge's event is applied on top.
            always_ff @(posedge CLK or posedge ASYNCRESET) begin
                if (ASYNCRESET) begin
                    r_count    <= '0;
                    r_drop     <= 1'b0;
                    r_mismatch <= 1'b0;
                    r_timeout  <= 1'b0;
                end else begin
                    if (mon.clear) begin
                        r_count <= w_xfer ? CNT_W'(1) : '0;
                    end else if (w_xfer && (r_count != CNT_MAX)) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                    r_drop     <= (r_drop     & ~mon.clear) | w_drop;
                    r_mismatch <= (r_mismatch & ~mon.clear) | w_mismatch;
                    r_timeout  <= (r_timeout  & ~mon.clear) | w_timeout;
                end
            end

            assign w_err_drop[gi]                  = r_drop;
            assign w_err_data[gi]                  = r_mismatch;
            assign w_err_timeout[gi]               = r_timeout;
            assign w_xfer_count[gi*CNT_W +: CNT_W] = r_count;
        end
    endgenerate

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_any_error <= 1'b0;
        end else begin
            r_any_error <= |{w_err_drop, w_err_data, w_err_timeout};
        end
    end

    assign mon.xfer_count  = w_xfer_count;
    assign mon.err_drop    = w_err_drop;
    assign mon.err_data    = w_err_data;
    assign mon.err_timeout = w_err_timeout;
    assign mon.any_error   = r_any_error;
endmodule

// File: tb/tb_handshake_monitor.sv
// Table-driven scoreboard bench for handshake_monitor (N_CH=3, DATA_W=4,
// CNT_W=8, TIMEOUT=4); one line printed per applied vector.
module tb_handshake_monitor;
    localparam int N_CH    = 3;
    localparam int DATA_W  = 4;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 4;

    typedef struct {
        logic [2:0]  valid;
        logic [2:0]  ready;
        logic [11:0] data;
        logic        clear;
        logic [23:0] cnt;
        logic [2:0]  drop;
        logic [2:0]  dat;
        logic [2:0]  to;
    } vec_t;

    typedef struct {
        logic [23:0] cnt;
        logic [2:0]  drop;
        logic [2:0]  dat;
        logic [2:0]  to;
        logic        any;
    } exp_t;

    logic CLK = 1'b0;
    logic ASYNCRESET = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic prev_any = 1'b0;
    exp_t exp_q[$];
    vec_t tbl[28];

    handshake_monitor_if #(.N_CH(N_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) mon ();

    handshake_monitor #(
        .N_CH(N_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK),
        .ASYNCRESET(ASYNCRESET),
        .mon(mon)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic [2:0] v, input logic [2:0] r, input logic [11:0] d,
                                input logic c, input logic [23:0] cnt, input logic [2:0] drop,
                                input logic [2:0] dat, input logic [2:0] to);
        vec_t x;
        x.valid = v; x.ready = r; x.data = d; x.clear = c;
        x.cnt = cnt; x.drop = drop; x.dat = dat; x.to = to;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Drive one vector, queue its expectation, then compare at the following negedge.
    task automatic drive(input vec_t v, input string tag);
        exp_t e;
        mon.valid = v.valid;
        mon.ready = v.ready;
        mon.data  = v.data;
        mon.clear = v.clear;
        e.cnt = v.cnt; e.drop = v.drop; e.dat = v.dat; e.to = v.to; e.any = prev_any;
        prev_any = |{v.drop, v.dat, v.to};
        exp_q.push_back(e);
        @(negedge CLK);
        if (exp_q.size() == 0) begin
            chk({tag, " scoreboard"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, " xfer_count"},  32'(mon.xfer_count),  32'(e.cnt));
            chk({tag, " err_drop"},    32'(mon.err_drop),    32'(e.drop));
            chk({tag, " err_data"},    32'(mon.err_data),    32'(e.dat));
            chk({tag, " err_timeout"}, 32'(mon.err_timeout), 32'(e.to));
            chk({tag, " any_error"},   32'(mon.any_error),   32'(e.any));
        end
        $display("%s v=%b r=%b d=%h clr=%b cnt=%h drop=%b dat=%b to=%b any=%b", tag,
                 v.valid, v.ready, v.data, v.clear, mon.xfer_count, mon.err_drop,
                 mon.err_data, mon.err_timeout, mon.any_error);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " xfer_count"},  32'(mon.xfer_count),  32'd0);
        chk({tag, " err_drop"},    32'(mon.err_drop),    32'd0);
        chk({tag, " err_data"},    32'(mon.err_data),    32'd0);
        chk({tag, " err_timeout"}, 32'(mon.err_timeout), 32'd0);
        chk({tag, " any_error"},   32'(mon.any_error),   32'd0);
        $display("%s cnt=%h drop=%b dat=%b to=%b any=%b", tag, mon.xfer_count,
                 mon.err_drop, mon.err_data, mon.err_timeout, mon.any_error);
    endtask

    initial begin
        // Scenario 1: five ch0 transfers, data 0..4.
        tbl[0]  = mk(3'b001, 3'b001, 12'h000, 1'b0, 24'h000001, 3'b000, 3'b000, 3'b000);
        tbl[1]  = mk(3'b001, 3'b001, 12'h001, 1'b0, 24'h000002, 3'b000, 3'b000, 3'b000);
        tbl[2]  = mk(3'b001, 3'b001, 12'h002, 1'b0, 24'h000003, 3'b000, 3'b000, 3'b000);
        tbl[3]  = mk(3'b001, 3'b001, 12'h003, 1'b0, 24'h000004, 3'b000, 3'b000, 3'b000);
        tbl[4]  = mk(3'b001, 3'b001, 12'h004, 1'b0, 24'h000005, 3'b000, 3'b000, 3'b000);
        // Scenario 2: ch1 stalls twice then withdraws valid; then ready-only idle cycle.
        tbl[5]  = mk(3'b010, 3'b000, 12'h0A0, 1'b0, 24'h000005, 3'b000, 3'b000, 3'b000);
        tbl[6]  = mk(3'b010, 3'b000, 12'h0A0, 1'b0, 24'h000005, 3'b000, 3'b000, 3'b000);
        tbl[7]  = mk(3'b000, 3'b000, 12'h000, 1'b0, 24'h000005, 3'b010, 3'b000, 3'b000);
        tbl[8]  = mk(3'b000, 3'b111, 12'h000, 1'b0, 24'h000005, 3'b010, 3'b000, 3'b000);
        // Scenario 3: ch2 payload changes mid-stall, then transfers.
        tbl[9]  = mk(3'b100, 3'b000, 12'h500, 1'b0, 24'h000005, 3'b010, 3'b000, 3'b000);
        tbl[10] = mk(3'b100, 3'b000, 12'h600, 1'b0, 24'h000005, 3'b010, 3'b100, 3'b000);
        tbl[11] = mk(3'b100, 3'b100, 12'h600, 1'b0, 24'h010005, 3'b010, 3'b100, 3'b000);
        // Scenario 4: ch0 stalls 4 edges (timeout), 6 more, then transfers.
        tbl[12] = mk(3'b001, 3'b000, 12'h007, 1'b0, 24'h010005, 3'b010, 3'b100, 3'b000);
        tbl[13] = mk(3'b001, 3'b000, 12'h007, 1'b0, 24'h010005, 3'b010, 3'b100, 3'b000);
        tbl[14] = mk(3'b001, 3'b000, 12'h007, 1'b0, 24'h010005, 3'b010, 3'b100, 3'b000);
        tbl[15] = mk(3'b001, 3'b000, 12'h007, 1'b0, 24'h010005, 3'b010, 3'b100, 3'b001);
        for (int i = 16; i < 22; i++)
            tbl[i] = mk(3'b001, 3'b000, 12'h007, 1'b0, 24'h010005, 3'b010, 3'b100, 3'b001);
        tbl[22] = mk(3'b001, 3'b001, 12'h007, 1'b0, 24'h010006, 3'b010, 3'b100, 3'b001);
        // Independence: ch1 idle transfers while ch0 stalls then completes.
        tbl[23] = mk(3'b011, 3'b010, 12'h0B3, 1'b0, 24'h010106, 3'b010, 3'b100, 3'b001);
        tbl[24] = mk(3'b011, 3'b011, 12'h0C3, 1'b0, 24'h010207, 3'b010, 3'b100, 3'b001);
        // Clear coinciding with a ch1 drop keeps the new drop flag.
        tbl[25] = mk(3'b010, 3'b000, 12'h0D0, 1'b0, 24'h010207, 3'b010, 3'b100, 3'b001);
        tbl[26] = mk(3'b000, 3'b000, 12'h000, 1'b1, 24'h000000, 3'b010, 3'b000, 3'b000);
        tbl[27] = mk(3'b000, 3'b000, 12'h000, 1'b1, 24'h000000, 3'b000, 3'b000, 3'b000);

        mon.valid = '0; mon.ready = '0; mon.data = '0; mon.clear = 1'b0;
        repeat (2) @(negedge CLK);
        chk_all_zero("reset_held");
        ASYNCRESET = 1'b0;
        @(negedge CLK);
        chk_all_zero("reset_released");

        for (int i = 0; i < 28; i++) drive(tbl[i], $sformatf("vec%0d", i));

        // Scenario 5: saturate ch0 count, then clear with a same-cycle transfer.
        for (int i = 0; i < 256; i++)
            drive(mk(3'b001, 3'b001, 12'h001, 1'b0, {16'h0000, (i >= 254) ? 8'hFF : 8'(i + 1)},
                     3'b000, 3'b000, 3'b000), $sformatf("sat%0d", i));
        drive(mk(3'b100, 3'b000, 12'h200, 1'b0, 24'h0000FF, 3'b000, 3'b000, 3'b000), "sat_stall");
        drive(mk(3'b000, 3'b000, 12'h000, 1'b0, 24'h0000FF, 3'b100, 3'b000, 3'b000), "sat_drop");
        drive(mk(3'b001, 3'b001, 12'h000, 1'b1, 24'h000001, 3'b000, 3'b000, 3'b000), "clr_xfer");
        drive(mk(3'b000, 3'b000, 12'h000, 1'b0, 24'h000001, 3'b000, 3'b000, 3'b000), "clr_after");

        // Scenario 6: asynchronous reset mid-stall with error bits set.
        drive(mk(3'b100, 3'b000, 12'h300, 1'b0, 24'h000001, 3'b000, 3'b000, 3'b000), "rst_stall2");
        drive(mk(3'b000, 3'b000, 12'h000, 1'b0, 24'h000001, 3'b100, 3'b000, 3'b000), "rst_drop2");
        drive(mk(3'b010, 3'b000, 12'h0E0, 1'b0, 24'h000001, 3'b100, 3'b000, 3'b000), "rst_stall1");
        #2 ASYNCRESET = 1'b1;
        #1 chk_all_zero("async_reset");
        exp_q.delete();
        prev_any = 1'b0;
        #1 ASYNCRESET = 1'b0;
        drive(mk(3'b000, 3'b000, 12'h000, 1'b0, 24'h000000, 3'b000, 3'b000, 3'b000), "post_rst");
        drive(mk(3'b010, 3'b010, 12'h0F0, 1'b0, 24'h000100, 3'b000, 3'b000, 3'b000), "post_xfer");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
